vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_pkg.sv | 26 ++
 rtl/vga_sync_gen_sync_delay_line.sv | 34 +++
 rtl/vga_sync_gen.sv | 96 +++++++++
 tb/tb_vga_sync_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA raster timing constants (640x480 @ 60 Hz defaults) and helpers,
// reused by the pattern/colour stages so they need not restate the geometry.
package vga_sync_gen_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // True when lo <= pos < hi.
  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (pos >= POS_W'(lo)) && (pos < POS_W'(hi));
  endfunction

endpackage

// File: rtl/vga_sync_gen_sync_delay_line.sv
// Clock-enabled shift register that resets to 1; DEPTH = 0 is a wire.
// Used to line the sync outputs up with a delayed RGB pipeline.
module vga_sync_gen_sync_delay_line #(
  parameter int unsigned DEPTH = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, ce};
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
      if (reset) begin
        stage <= '1;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: position counters, visible flag,
// active-low syncs (optionally delayed) and line/frame strobes, all registered.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter int unsigned SYNC_DELAY = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_visible,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line_start,
  output logic             o_frame_start
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [POS_W-1:0] hpos_next_c;
  logic [POS_W-1:0] vpos_next_c;
  logic             visible_next_c;
  logic             hsync_next_c;
  logic             vsync_next_c;
  logic             hsync_pre;
  logic             vsync_pre;

  // Next raster position and the flags that belong to it, so flags register in step.
  always_comb begin
    hpos_next_c = o_hpos + POS_W'(1);
    vpos_next_c = o_vpos;
    if (o_hpos == POS_W'(H_TOTAL - 1)) begin
      hpos_next_c = '0;
      vpos_next_c = (o_vpos == POS_W'(V_TOTAL - 1)) ? '0 : o_vpos + POS_W'(1);
    end
    visible_next_c = (hpos_next_c < POS_W'(H_VISIBLE)) && (vpos_next_c < POS_W'(V_VISIBLE));
    hsync_next_c   = !in_window(hpos_next_c, H_SYNC_START, H_SYNC_END);
    vsync_next_c   = !in_window(vpos_next_c, V_SYNC_START, V_SYNC_END);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hpos        <= POS_W'(H_TOTAL - 1);
      o_vpos        <= POS_W'(V_TOTAL - 1);
      o_visible     <= 1'b0;
      hsync_pre     <= 1'b1;
      vsync_pre     <= 1'b1;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_ce) begin
      o_hpos        <= hpos_next_c;
      o_vpos        <= vpos_next_c;
      o_visible     <= visible_next_c;
      hsync_pre     <= hsync_next_c;
      vsync_pre     <= vsync_next_c;
      o_line_start  <= (hpos_next_c == '0);
      o_frame_start <= (hpos_next_c == '0) && (vpos_next_c == '0);
    end else begin
      // Strobes mark an advance, so a held cycle never repeats them.
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

  vga_sync_gen_sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hsync_dly (
    .clk   (i_clk),
    .reset (i_reset),
    .ce    (i_ce),
    .d     (hsync_pre),
    .q     (o_hsync)
  );

  vga_sync_gen_sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vsync_dly (
    .clk   (i_clk),
    .reset (i_reset),
    .ce    (i_ce),
    .d     (vsync_pre),
    .q     (o_vsync)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing (delay 0 and 2) plus a shrunken
// geometry (delay 1) so whole frames fit in a short run.
module tb_vga_sync_gen;

  localparam int unsigned S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int unsigned S_VV = 6,  S_VF = 2, S_VS = 2, S_VB = 3;

  typedef struct {
    int unsigned hv, hf, hs, hb, vv, vf, vs, vb, d;
  } cfg_t;

  typedef struct {
    int unsigned h, v;
    bit          ls, fs, hs_o, vs_o;
    bit [7:0]    hh, vh;
  } mst_t;

  logic       clk;
  logic       ce;
  logic       rst;

  logic [9:0] hpos_a, vpos_a, hpos_d, vpos_d, hpos_s, vpos_s;
  logic       vis_a, hs_a, vs_a, ls_a, fs_a;
  logic       vis_d, hs_d, vs_d, ls_d, fs_d;
  logic       vis_s, hs_s, vs_s, ls_s, fs_s;

  int         n_tests = 0;
  int         n_fail  = 0;

  cfg_t       cfg_a, cfg_d, cfg_s;
  mst_t       m_a, m_d, m_s;
  logic [24:0] exp_a_q[$];
  logic [24:0] exp_d_q[$];
  logic [24:0] exp_s_q[$];

  // Line/frame monitors
  bit mon_en = 0;
  int hs_lo_cnt = 0, d_lo_cnt = 0, first_lo = -1, last_lo = -1;
  int vis_fall = -1, d_fall = -1, ls_cnt = 0;
  int s_en = 0, s_last = -1, s_vlow = 0;

  vga_sync_gen u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_ce(ce),
    .o_hpos(hpos_a), .o_vpos(vpos_a), .o_visible(vis_a),
    .o_hsync(hs_a), .o_vsync(vs_a),
    .o_line_start(ls_a), .o_frame_start(fs_a)
  );

  vga_sync_gen #(.SYNC_DELAY(2)) u_dut_d (
    .i_clk(clk), .i_reset(rst), .i_ce(ce),
    .o_hpos(hpos_d), .o_vpos(vpos_d), .o_visible(vis_d),
    .o_hsync(hs_d), .o_vsync(vs_d),
    .o_line_start(ls_d), .o_frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(1)
  ) u_dut_s (
    .i_clk(clk), .i_reset(rst), .i_ce(ce),
    .o_hpos(hpos_s), .o_vpos(vpos_s), .o_visible(vis_s),
    .o_hsync(hs_s), .o_vsync(vs_s),
    .o_line_start(ls_s), .o_frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster: position counts, windows, and an N-deep history for the syncs.
  function automatic mst_t model_step(input cfg_t c, input mst_t s, input bit en, input bit r);
    int unsigned ht = c.hv + c.hf + c.hs + c.hb;
    int unsigned vt = c.vv + c.vf + c.vs + c.vb;
    bit raw_h, raw_v;
    mst_t n = s;
    if (r) begin
      n.h = ht - 1; n.v = vt - 1;
      n.ls = 0; n.fs = 0; n.hs_o = 1; n.vs_o = 1;
      n.hh = '1; n.vh = '1;
    end else if (!en) begin
      n.ls = 0; n.fs = 0;
    end else begin
      n.h = s.h + 1;
      if (n.h == ht) begin
        n.h = 0;
        n.v = (s.v + 1 == vt) ? 0 : s.v + 1;
      end
      n.ls = (n.h == 0);
      n.fs = (n.h == 0) && (n.v == 0);
      raw_h = !((n.h >= c.hv + c.hf) && (n.h < c.hv + c.hf + c.hs));
      raw_v = !((n.v >= c.vv + c.vf) && (n.v < c.vv + c.vf + c.vs));
      n.hs_o = (c.d == 0) ? raw_h : s.hh[3'(c.d - 1)];
      n.vs_o = (c.d == 0) ? raw_v : s.vh[3'(c.d - 1)];
      n.hh = {s.hh[6:0], raw_h};
      n.vh = {s.vh[6:0], raw_v};
    end
    return n;
  endfunction

  function automatic logic [24:0] exp_vec(input cfg_t c, input mst_t s);
    bit vis = (s.h < c.hv) && (s.v < c.vv);
    return {10'(s.h), 10'(s.v), vis, s.hs_o, s.vs_o, s.ls, s.fs};
  endfunction

  // One clock: drive, queue expectations, then compare after the edge.
  task automatic step(input bit en, input bit r);
    @(negedge clk);
    ce  = en;
    rst = r;
    m_a = model_step(cfg_a, m_a, en, r);
    m_d = model_step(cfg_d, m_d, en, r);
    m_s = model_step(cfg_s, m_s, en, r);
    exp_a_q.push_back(exp_vec(cfg_a, m_a));
    exp_d_q.push_back(exp_vec(cfg_d, m_d));
    exp_s_q.push_back(exp_vec(cfg_s, m_s));
    @(posedge clk);
    #1;
    check_eq("dut_a", 32'({hpos_a, vpos_a, vis_a, hs_a, vs_a, ls_a, fs_a}), 32'(exp_a_q.pop_front()));
    check_eq("dut_d", 32'({hpos_d, vpos_d, vis_d, hs_d, vs_d, ls_d, fs_d}), 32'(exp_d_q.pop_front()));
    check_eq("dut_s", 32'({hpos_s, vpos_s, vis_s, hs_s, vs_s, ls_s, fs_s}), 32'(exp_s_q.pop_front()));

    if (mon_en && !r && vpos_a == 10'd0) begin
      if (!hs_a) begin
        hs_lo_cnt++;
        if (first_lo < 0) first_lo = int'(hpos_a);
        last_lo = int'(hpos_a);
      end
      if (!hs_d) d_lo_cnt++;
      if (!hs_d && d_fall < 0) d_fall = int'(hpos_d);
      if (!vis_a && vis_fall < 0) vis_fall = int'(hpos_a);
    end
    if (mon_en && !r && ls_a) ls_cnt++;

    if (r) begin
      s_last = -1;
      s_vlow = 0;
    end else if (en) begin
      s_en++;
      if (!vs_s) s_vlow++;
      if (fs_s) begin
        if (s_last >= 0) begin
          check_eq("s_frame_period", 32'(s_en - s_last),
                   32'((S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB)));
          check_eq("s_vsync_width", 32'(s_vlow), 32'(S_VS * (S_HV + S_HF + S_HS + S_HB)));
        end
        s_last = s_en;
        s_vlow = 0;
      end
    end
  endtask

  initial begin
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    cfg_s = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1};
    ce  = 1'b0;
    rst = 1'b1;

    // Reset dominates i_ce
    step(1, 1);
    step(0, 1);
    check_eq("rst_hpos", 32'(hpos_a), 32'd799);
    check_eq("rst_vpos", 32'(vpos_a), 32'd524);
    check_eq("rst_flags", 32'({vis_a, hs_a, vs_a, ls_a, fs_a}), 32'b01100);
    check_eq("rst_d_sync", 32'({hs_d, vs_d}), 32'b11);

    step(1, 0);
    check_eq("first_pos", 32'({hpos_a, vpos_a}), 32'd0);
    check_eq("first_flags", 32'({vis_a, hs_a, vs_a, ls_a, fs_a}), 32'b11111);

    // Two full lines with i_ce held high
    mon_en = 1;
    repeat (1600) step(1, 0);
    mon_en = 0;
    check_eq("hsync_width", 32'(hs_lo_cnt), 32'd96);
    check_eq("hsync_first", 32'(first_lo), 32'd656);
    check_eq("hsync_last", 32'(last_lo), 32'd751);
    check_eq("visible_fall", 32'(vis_fall), 32'd640);
    check_eq("dly2_fall", 32'(d_fall), 32'd658);
    check_eq("dly2_width", 32'(d_lo_cnt), 32'd96);
    check_eq("line_starts", 32'(ls_cnt), 32'd2);
    check_eq("after_2_lines", 32'({hpos_a, vpos_a}), 32'({10'd0, 10'd2}));

    // Hold for two cycles right at the line wrap
    repeat (798) step(1, 0);
    step(1, 0);
    check_eq("pre_hold_hpos", 32'(hpos_a), 32'd799);
    step(0, 0);
    check_eq("hold1", 32'({hpos_a, vpos_a, ls_a}), 32'({10'd799, 10'd2, 1'b0}));
    step(0, 0);
    check_eq("hold2", 32'({hpos_a, vpos_a, ls_a}), 32'({10'd799, 10'd2, 1'b0}));
    step(1, 0);
    check_eq("resume_wrap", 32'({hpos_a, vpos_a, ls_a}), 32'({10'd0, 10'd3, 1'b1}));
    step(1, 0);
    check_eq("resume_next", 32'({hpos_a, vpos_a, ls_a}), 32'({10'd1, 10'd3, 1'b0}));

    // Random clock-enable pattern
    repeat (2000) step($urandom_range(0, 3) != 0, 0);

    // Mid-frame reset with i_ce low, then restart
    repeat (37) step(1, 0);
    step(0, 1);
    check_eq("midrst_a", 32'({hpos_a, vpos_a, vis_a, hs_a, vs_a, ls_a, fs_a}),
             32'({10'd799, 10'd524, 5'b01100}));
    check_eq("midrst_s", 32'({hpos_s, vpos_s}), 32'({10'd31, 10'd12}));
    step(1, 0);
    check_eq("midrst_restart", 32'({hpos_a, vpos_a, fs_a}), 32'({10'd0, 10'd0, 1'b1}));
    check_eq("midrst_restart_s", 32'({hpos_s, vpos_s, fs_s}), 32'({10'd0, 10'd0, 1'b1}));

    repeat (900) step(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
